// File: rtl/source_burst_pacer_pkg.sv
// Shared types and widths for the SSD write-path burst pacer.
// Imported by the pacer top and its skid FIFO.
package source_burst_pacer_pkg;

    typedef enum logic {
        S_BURST = 1'b0,
        S_GAP   = 1'b1
    } state_t;

    localparam int unsigned BURST_CNT_W = 16;
    localparam int unsigned FIFO_DEPTH  = 2;

    // Bits needed to hold 0..max_val, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/source_burst_pacer_fifo.sv
// Two-entry registered FIFO with its head word visible combinationally.
// Writes while full and reads while empty are ignored.
module src_skid_fifo
    import source_burst_pacer_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem0_q, mem0_d;
    logic [DATA_W-1:0] mem1_q, mem1_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              do_wr, do_rd;

    assign empty   = (cnt_q == 2'd0);
    assign full    = (cnt_q == 2'(FIFO_DEPTH));
    assign rd_data = rd_ptr_q ? mem1_q : mem0_q;

    // A write into a full FIFO is refused even if a read frees a slot this cycle.
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    always_comb begin
        mem0_d   = mem0_q;
        mem1_d   = mem1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (do_wr) begin
            if (wr_ptr_q) begin
                mem1_d = wr_data;
            end else begin
                mem0_d = wr_data;
            end
            wr_ptr_d = ~wr_ptr_q;
        end

        if (do_rd) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            mem0_q   <= '0;
            mem1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mem0_q   <= mem0_d;
            mem1_q   <= mem1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/source_burst_pacer.sv
// Paces a buffered valid/ready word stream into bursts of BURST_LEN words,
// each followed by GAP_LEN idle cycles; flags burst-last words and counts bursts.
module source_burst_pacer
    import source_burst_pacer_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned GAP_LEN   = 1
) (
    input  logic                   clk,
    input  logic                   nRST,
    input  logic                   cfg_en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_last,
    output logic [BURST_CNT_W-1:0] burst_cnt
);

    localparam int unsigned WC_W = cnt_width(BURST_LEN);
    localparam int unsigned GC_W = cnt_width(GAP_LEN);

    localparam logic [WC_W-1:0] LAST_IDX = WC_W'(BURST_LEN - 1);
    localparam logic [GC_W-1:0] GAP_INIT = GC_W'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);

    state_t                 state_q, state_d;
    logic [WC_W-1:0]        word_cnt_q, word_cnt_d;
    logic [GC_W-1:0]        gap_cnt_q, gap_cnt_d;
    logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic fifo_empty;
    logic fifo_full;
    logic wr;
    logic rd;

    src_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .nRST    (nRST),
        .wr_en   (wr),
        .wr_data (in_data),
        .rd_en   (rd),
        .rd_data (out_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign in_ready  = ~fifo_full;
    assign wr        = in_valid & in_ready;
    assign out_valid = ~fifo_empty & (state_q == S_BURST);
    assign rd        = out_valid & out_ready;
    assign out_last  = out_valid & cfg_en & (word_cnt_q == LAST_IDX);
    assign burst_cnt = burst_cnt_q;

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        burst_cnt_d = burst_cnt_q;

        if (!cfg_en) begin
            // Pass-through: abandon any gap and restart counting on re-enable.
            state_d    = S_BURST;
            word_cnt_d = '0;
            gap_cnt_d  = '0;
        end else begin
            case (state_q)
                S_BURST: begin
                    if (rd) begin
                        if (out_last) begin
                            word_cnt_d  = '0;
                            burst_cnt_d = burst_cnt_q + BURST_CNT_W'(1);
                            if (GAP_LEN > 0) begin
                                gap_cnt_d = GAP_INIT;
                                state_d   = S_GAP;
                            end
                        end else begin
                            word_cnt_d = word_cnt_q + WC_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_d = S_BURST;
                    end else begin
                        gap_cnt_d = gap_cnt_q - GC_W'(1);
                    end
                end
                default: begin
                    state_d = S_BURST;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= S_BURST;
            word_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_source_burst_pacer.sv
// Directed bench for source_burst_pacer: default pacing (8/1) and a 4/3 variant
// driven from shared stimulus, with per-scenario inline checks.
module tb_source_burst_pacer;

    logic        clk;
    logic        nRST;
    logic        cfg_en;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_last;
    logic [15:0] a_out_data, a_burst_cnt;
    logic        b_in_ready, b_out_valid, b_out_last;
    logic [15:0] b_out_data, b_burst_cnt;

    logic        sel;
    logic        s_ir, s_ov, s_ol;
    logic [15:0] s_od, s_bcnt;

    int n_cmp;
    int n_bad;
    int next_in;
    int in_limit;

    source_burst_pacer #(
        .DATA_W    (16),
        .BURST_LEN (8),
        .GAP_LEN   (1)
    ) u_dut_a (
        .clk       (clk),
        .nRST      (nRST),
        .cfg_en    (cfg_en),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .in_data   (in_data),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_data  (a_out_data),
        .out_last  (a_out_last),
        .burst_cnt (a_burst_cnt)
    );

    source_burst_pacer #(
        .DATA_W    (16),
        .BURST_LEN (4),
        .GAP_LEN   (3)
    ) u_dut_b (
        .clk       (clk),
        .nRST      (nRST),
        .cfg_en    (cfg_en),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .in_data   (in_data),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_data  (b_out_data),
        .out_last  (b_out_last),
        .burst_cnt (b_burst_cnt)
    );

    assign s_ir   = sel ? b_in_ready  : a_in_ready;
    assign s_ov   = sel ? b_out_valid : a_out_valid;
    assign s_ol   = sel ? b_out_last  : a_out_last;
    assign s_od   = sel ? b_out_data  : a_out_data;
    assign s_bcnt = sel ? b_burst_cnt : a_burst_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock; upstream data advances when the selected DUT accepted a word.
    task automatic step();
        logic acc;
        acc = in_valid && s_ir;
        @(posedge clk);
        #1;
        if (acc) begin
            next_in++;
            in_data = 16'(next_in);
            if (next_in >= in_limit) in_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        nRST      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        cfg_en    = 1'b1;
        @(posedge clk);
        #1;
        nRST = 1'b1;
    endtask

    // Streams words 0..nwords-1 and checks order, out_last, idle gaps and burst_cnt.
    task automatic run_stream(input int nwords, input int burst, input int gap,
                              input int stall_at, input int stall_len, input int dis_at);
        int   got, idle, exp_bursts, exp_gap;
        logic rd, exp_l, prev_last;
        bit   stalled, full_in_gap;
        next_in     = 0;
        in_limit    = nwords;
        in_data     = '0;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        cfg_en      = 1'b1;
        got         = 0;
        idle        = 0;
        exp_bursts  = 0;
        prev_last   = 1'b0;
        stalled     = 1'b0;
        full_in_gap = 1'b0;
        for (int cyc = 0; cyc < 400 && got < nwords; cyc++) begin
            if (stall_at >= 0 && !stalled && s_ov && s_od == 16'(stall_at)) begin
                stalled   = 1'b1;
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    n_cmp++;
                    if (s_ov !== 1'b1 || s_od !== 16'(stall_at) || s_ol !== 1'b0) begin
                        n_bad++;
                        $display("FAIL stall_hold: valid=%0b data=%0d last=%0b required valid=1 data=%0d last=0",
                                 s_ov, s_od, s_ol, stall_at);
                    end
                end
                n_cmp++;
                if (s_ir !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stall_full: in_ready=%0b required 0", s_ir);
                end
                out_ready = 1'b1;
            end
            rd = s_ov && out_ready;
            if (rd) begin
                exp_l = ((dis_at < 0) || (got <= dis_at)) && ((got % burst) == (burst - 1));
                n_cmp++;
                if (s_od !== 16'(got)) begin
                    n_bad++;
                    $display("FAIL data: word %0d got %0d required %0d", got, s_od, got);
                end
                n_cmp++;
                if (s_ol !== exp_l) begin
                    n_bad++;
                    $display("FAIL last: word %0d got %0b required %0b", got, s_ol, exp_l);
                end
                if (got > 0) begin
                    exp_gap = prev_last ? gap : 0;
                    n_cmp++;
                    if (idle != exp_gap) begin
                        n_bad++;
                        $display("FAIL gap: before word %0d idle=%0d required %0d", got, idle, exp_gap);
                    end
                end
                prev_last = exp_l;
                if (exp_l) exp_bursts++;
                got++;
                idle = 0;
            end else if (got > 0) begin
                idle++;
                if (s_ir === 1'b0) full_in_gap = 1'b1;
            end
            step();
            if (dis_at >= 0 && cfg_en && got == dis_at + 1) begin
                n_cmp++;
                if (s_ov !== 1'b0) begin
                    n_bad++;
                    $display("FAIL gap_before_disable: out_valid=%0b required 0", s_ov);
                end
                cfg_en = 1'b0;
            end
        end
        n_cmp++;
        if (got != nwords) begin
            n_bad++;
            $display("FAIL stream_timeout: received %0d words required %0d", got, nwords);
        end
        n_cmp++;
        if (s_bcnt !== 16'(exp_bursts)) begin
            n_bad++;
            $display("FAIL burst_cnt: got %0d required %0d", s_bcnt, exp_bursts);
        end
        if (gap >= 2) begin
            n_cmp++;
            if (!full_in_gap) begin
                n_bad++;
                $display("FAIL gap_fill: in_ready never dropped during gap, required a drop to 0");
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        sel       = 1'b0;
        nRST      = 1'b0;
        cfg_en    = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h00A5;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (s_ov !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0b required 0", s_ov); end
        n_cmp++;
        if (s_bcnt !== 16'd0) begin n_bad++; $display("FAIL rst_bcnt: got %0d required 0", s_bcnt); end
        n_cmp++;
        if (s_ir !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %0b required 1", s_ir); end
        n_cmp++;
        if (s_ol !== 1'b0 || s_od !== 16'd0) begin
            n_bad++;
            $display("FAIL rst_data: last=%0b data=%0d required last=0 data=0", s_ol, s_od);
        end
        nRST     = 1'b1;
        next_in  = 0;
        in_limit = 1;
        step();
        n_cmp++;
        if (s_ov !== 1'b1 || s_od !== 16'h00A5) begin
            n_bad++;
            $display("FAIL first_word: valid=%0b data=%0h required valid=1 data=a5", s_ov, s_od);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stream();
        sel = 1'b0;
        do_reset();
        run_stream(24, 8, 1, -1, 0, -1);
    endtask

    task automatic test_long_gap();
        sel = 1'b1;
        do_reset();
        run_stream(8, 4, 3, -1, 0, -1);
        sel = 1'b0;
    endtask

    task automatic test_stall();
        sel = 1'b0;
        do_reset();
        run_stream(16, 8, 1, 5, 5, -1);
    endtask

    task automatic test_cfg_disable();
        sel = 1'b0;
        do_reset();
        run_stream(28, 8, 1, -1, 0, 7);
        cfg_en = 1'b1;
    endtask

    task automatic test_reset_midburst();
        int reads;
        sel       = 1'b0;
        do_reset();
        next_in   = 0;
        in_limit  = 100;
        in_data   = '0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        reads     = 0;
        for (int i = 0; i < 50 && reads < 6; i++) begin
            if (s_ov && out_ready) reads++;
            step();
        end
        out_ready = 1'b0;
        for (int i = 0; i < 10 && s_ir; i++) step();
        n_cmp++;
        if (s_ir !== 1'b0 || s_ov !== 1'b1 || s_od !== 16'd6) begin
            n_bad++;
            $display("FAIL pre_reset: ready=%0b valid=%0b data=%0d required ready=0 valid=1 data=6",
                     s_ir, s_ov, s_od);
        end
        nRST = 1'b0;
        #1;
        n_cmp++;
        if (s_ov !== 1'b0 || s_ir !== 1'b1 || s_bcnt !== 16'd0 || s_ol !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: valid=%0b ready=%0b bcnt=%0d last=%0b required 0/1/0/0",
                     s_ov, s_ir, s_bcnt, s_ol);
        end
        in_valid = 1'b0;
        #1;
        nRST = 1'b1;
        run_stream(16, 8, 1, -1, 0, -1);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        next_in   = 0;
        in_limit  = 0;
        sel       = 1'b0;
        nRST      = 1'b0;
        cfg_en    = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #3;
        test_reset();
        test_stream();
        test_long_gap();
        test_stall();
        test_cfg_disable();
        test_reset_midburst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
